// File: rtl/hasti_arbiter_pkg.sv
// rtl/hasti_arbiter_pkg.sv - shared types for the two-master HASTI arbiter
package hasti_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef logic [0:0] owner_t;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } own_state_t;

  localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/hasti_arbiter_ctrl.sv
// rtl/hasti_arbiter_ctrl.sv - address/data ownership control for hasti_arbiter
// HASTI_ARB_RR_EN selects round-robin tie breaking; fixed m0 priority otherwise.
module hasti_arbiter_ctrl
  import hasti_arbiter_pkg::*;
#(
  parameter int unsigned DEFAULT_OWNER = 0
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] m0_htrans,
  input  logic       m0_hmastlock,
  input  logic [1:0] m1_htrans,
  input  logic       m1_hmastlock,
  input  logic       s_hready,
  output logic       addr_owner,
  output logic       data_owner,
  output logic       data_valid
);

  localparam owner_t     RESET_OWNER = owner_t'(DEFAULT_OWNER);
  localparam own_state_t RESET_STATE = own_state_t'(RESET_OWNER);

  own_state_t state, state_nxt;
  logic [1:0] own_htrans;
  logic       own_lock;
  logic       own_idle;
  logic       req0, req1;
  logic       winner;

  assign req0       = m0_htrans[1];
  assign req1       = m1_htrans[1];
  assign own_htrans = (state == OWN1) ? m1_htrans : m0_htrans;
  assign own_lock   = (state == OWN1) ? m1_hmastlock : m0_hmastlock;
  // Only a plain unlocked IDLE releases the bus; locked IDLEs keep the sequence whole.
  assign own_idle   = (own_htrans == IDLE) && !own_lock;

`ifdef HASTI_ARB_RR_EN
  logic last_owner;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_owner <= RESET_OWNER;
    end else if (s_hready) begin
      last_owner <= addr_owner;
    end
  end

  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end
  end
`else
  always_comb begin
    winner = ~req0;
  end
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (s_hready && own_idle && (req0 || req1) && (winner != addr_owner)) begin
      state_nxt = own_state_t'(winner);
    end
  end

  always_comb begin
    addr_owner = (state == OWN1);
  end

  // The data phase follows whichever master owned the address phase that just completed.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      data_owner <= RESET_OWNER;
      data_valid <= 1'b0;
    end else if (s_hready) begin
      data_owner <= addr_owner;
      data_valid <= own_htrans[1];
    end
  end

endmodule

// File: rtl/hasti_arbiter.sv
// rtl/hasti_arbiter.sv - two-master AHB-Lite arbiter in front of hasti_bus
// Round-robin tie breaking is enabled by HASTI_ARB_RR_EN (see hasti_arbiter_ctrl).
module hasti_arbiter
  import hasti_arbiter_pkg::*;
#(
  parameter int unsigned DEFAULT_OWNER = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic [3:0]  m0_hprot,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hmastlock,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  output logic [31:0] m0_hrdata,
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic [3:0]  m1_hprot,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hmastlock,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [31:0] m1_hrdata,
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [2:0]  s_hburst,
  output logic [3:0]  s_hprot,
  output logic [1:0]  s_htrans,
  output logic        s_hmastlock,
  output logic [31:0] s_hwdata,
  input  logic        s_hready,
  input  logic        s_hresp,
  input  logic [31:0] s_hrdata,
  output logic        grant
);

  logic addr_owner;
  logic data_owner;
  logic data_valid;
  logic m0_data;
  logic m1_data;

  hasti_arbiter_ctrl #(
    .DEFAULT_OWNER(DEFAULT_OWNER)
  ) u_ctrl (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .m0_htrans    (m0_htrans),
    .m0_hmastlock (m0_hmastlock),
    .m1_htrans    (m1_htrans),
    .m1_hmastlock (m1_hmastlock),
    .s_hready     (s_hready),
    .addr_owner   (addr_owner),
    .data_owner   (data_owner),
    .data_valid   (data_valid)
  );

  assign grant = addr_owner;

  always_comb begin
    if (addr_owner) begin
      s_haddr     = m1_haddr;
      s_hwrite    = m1_hwrite;
      s_hsize     = m1_hsize;
      s_hburst    = m1_hburst;
      s_hprot     = m1_hprot;
      s_htrans    = m1_htrans;
      s_hmastlock = m1_hmastlock;
    end else begin
      s_haddr     = m0_haddr;
      s_hwrite    = m0_hwrite;
      s_hsize     = m0_hsize;
      s_hburst    = m0_hburst;
      s_hprot     = m0_hprot;
      s_htrans    = m0_htrans;
      s_hmastlock = m0_hmastlock;
    end
  end

  assign s_hwdata = data_owner ? m1_hwdata : m0_hwdata;

  assign m0_data = data_valid && !data_owner;
  assign m1_data = data_valid && data_owner;

  // A stalled requester sees hready low so it holds its address; an idle one sees it high.
  always_comb begin
    m0_hready = (!addr_owner || m0_data) ? s_hready : ~m0_htrans[1];
    m1_hready = (addr_owner || m1_data) ? s_hready : ~m1_htrans[1];
  end

  always_comb begin
    m0_hresp  = m0_data ? s_hresp : HRESP_OKAY;
    m0_hrdata = m0_data ? s_hrdata : 32'h0;
    m1_hresp  = m1_data ? s_hresp : HRESP_OKAY;
    m1_hrdata = m1_data ? s_hrdata : 32'h0;
  end

endmodule

// File: tb/tb_hasti_arbiter.sv
// tb/tb_hasti_arbiter.sv - self-checking bench for hasti_arbiter
module tb_hasti_arbiter;

  localparam logic [31:0] RKEY = 32'hA5A5_5A5A;

  logic        hclk;
  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr, s_haddr;
  logic        m0_hwrite, m1_hwrite, s_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize;
  logic [2:0]  m0_hburst, m1_hburst, s_hburst;
  logic [3:0]  m0_hprot, m1_hprot, s_hprot;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata, s_hwdata;
  logic        m0_hready, m1_hready, s_hready;
  logic        m0_hresp, m1_hresp, s_hresp;
  logic [31:0] m0_hrdata, m1_hrdata, s_hrdata;
  logic        grant;

  int checks = 0;
  int errors = 0;

  hasti_arbiter #(.DEFAULT_OWNER(0)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_htrans(m0_htrans), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_htrans(m1_htrans), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .grant(grant)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic step;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_all;
    m0_haddr = '0; m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_hburst = 3'd0; m0_hprot = 4'h3;
    m0_htrans = 2'b00; m0_hmastlock = 1'b0; m0_hwdata = '0;
    m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = 3'd2; m1_hburst = 3'd0; m1_hprot = 4'h3;
    m1_htrans = 2'b00; m1_hmastlock = 1'b0; m1_hwdata = '0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
  endtask

  task automatic set_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk);
    m0_htrans = tr; m0_haddr = a; m0_hwrite = wr; m0_hmastlock = lk;
  endtask

  task automatic set_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk);
    m1_htrans = tr; m1_haddr = a; m1_hwrite = wr; m1_hmastlock = lk;
  endtask

  task automatic test_reset;
    hresetn = 1'b0;
    idle_all();
    s_hrdata = 32'hFFFF_FFFF;
    s_hresp  = 1'b1;
    repeat (2) @(negedge hclk);
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0h want 0", grant); end
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %0h want 0", s_htrans); end
    checks++; if (m0_hready !== 1'b1 || m1_hready !== 1'b1) begin errors++; $display("FAIL reset_hready: got %0b%0b want 11", m0_hready, m1_hready); end
    checks++; if (m0_hresp !== 1'b0 || m1_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %0b%0b want 00", m0_hresp, m1_hresp); end
    checks++; if (m0_hrdata !== 32'h0 || m1_hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %0h %0h want 0 0", m0_hrdata, m1_hrdata); end
    step();
    hresetn = 1'b1;
    s_hrdata = '0;
    s_hresp  = 1'b0;
  endtask

  task automatic test_single_read;
    set_m0(2'b10, 32'h0000_0100, 1'b0, 1'b0);
    @(negedge hclk);
    checks++; if (s_haddr !== 32'h0000_0100 || s_htrans !== 2'b10) begin errors++; $display("FAIL single_fwd: got %0h/%0h want 100/2", s_haddr, s_htrans); end
    checks++; if (grant !== 1'b0 || m1_hready !== 1'b1) begin errors++; $display("FAIL single_grant: got grant %0b m1_hready %0b want 0 1", grant, m1_hready); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
    s_hrdata = 32'hCAFE_0100;
    @(negedge hclk);
    checks++; if (m0_hrdata !== 32'hCAFE_0100) begin errors++; $display("FAIL single_rdata: got %0h want cafe0100", m0_hrdata); end
    checks++; if (m1_hrdata !== 32'h0 || m0_hresp !== 1'b0) begin errors++; $display("FAIL single_other: got m1_hrdata %0h m0_hresp %0b want 0 0", m1_hrdata, m0_hresp); end
    step();
    s_hrdata = '0;
  endtask

  task automatic test_burst_handover;
    set_m0(2'b10, 32'h0000_1000, 1'b0, 1'b0);
    m0_hburst = 3'b011;
    set_m1(2'b10, 32'h4000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step();
        set_m0(2'b11, 32'h0000_1000 + 32'(4 * i), 1'b0, 1'b0);
      end
      @(negedge hclk);
      checks++; if (m1_hready !== 1'b0 || s_haddr !== 32'h0000_1000 + 32'(4 * i) || grant !== 1'b0) begin
        errors++; $display("FAIL burst_beat%0d: got m1_hready %0b haddr %0h grant %0b want 0 %0h 0", i, m1_hready, s_haddr, grant, 32'h1000 + 32'(4 * i));
      end
    end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
    m0_hburst = 3'b000;
    @(negedge hclk);
    checks++; if (s_htrans !== 2'b00 || m1_hready !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL burst_bubble: got htrans %0h m1_hready %0b grant %0b want 0 0 0", s_htrans, m1_hready, grant); end
    step();
    @(negedge hclk);
    checks++; if (grant !== 1'b1 || s_haddr !== 32'h4000_0000 || s_htrans !== 2'b10) begin errors++; $display("FAIL burst_switch: got grant %0b haddr %0h htrans %0h want 1 40000000 2", grant, s_haddr, s_htrans); end
    checks++; if (m1_hready !== 1'b1 || m0_hready !== 1'b1) begin errors++; $display("FAIL burst_switch_ready: got %0b%0b want 11", m0_hready, m1_hready); end
    step();
    set_m1(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge hclk);
    checks++; if (grant !== 1'b1 || s_htrans !== 2'b00) begin errors++; $display("FAIL park: got grant %0b htrans %0h want 1 0", grant, s_htrans); end
  endtask

  task automatic test_wait_states;
    step();
    set_m0(2'b10, 32'h0000_2000, 1'b1, 1'b0);
    @(negedge hclk);
    checks++; if (m0_hready !== 1'b0 || grant !== 1'b1) begin errors++; $display("FAIL ws_stall: got m0_hready %0b grant %0b want 0 1", m0_hready, grant); end
    step();
    @(negedge hclk);
    checks++; if (grant !== 1'b0 || s_haddr !== 32'h0000_2000 || s_hwrite !== 1'b1) begin errors++; $display("FAIL ws_fwd: got grant %0b haddr %0h hwrite %0b want 0 2000 1", grant, s_haddr, s_hwrite); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
    m0_hwdata = 32'h1234_5678;
    set_m1(2'b10, 32'h0000_5000, 1'b0, 1'b0);
    s_hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      @(negedge hclk);
      checks++; if (m0_hready !== 1'b0 || m1_hready !== 1'b0 || grant !== 1'b0 || s_hwdata !== 32'h1234_5678) begin
        errors++; $display("FAIL ws_wait%0d: got m0r %0b m1r %0b grant %0b wdata %0h want 0 0 0 12345678", i, m0_hready, m1_hready, grant, s_hwdata);
      end
    end
    step();
    s_hready = 1'b1;
    @(negedge hclk);
    checks++; if (m0_hready !== 1'b1 || m1_hready !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL ws_done: got m0r %0b m1r %0b grant %0b want 1 0 0", m0_hready, m1_hready, grant); end
    step();
    m0_hwdata = '0;
    @(negedge hclk);
    checks++; if (grant !== 1'b1 || s_haddr !== 32'h0000_5000 || m1_hready !== 1'b1) begin errors++; $display("FAIL ws_switch: got grant %0b haddr %0h m1r %0b want 1 5000 1", grant, s_haddr, m1_hready); end
    step();
    set_m1(2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_lock;
    set_m0(2'b10, 32'h0000_3000, 1'b0, 1'b1);
    @(negedge hclk);
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL lock_req: got grant %0b want 1", grant); end
    step();
    @(negedge hclk);
    checks++; if (grant !== 1'b0 || s_hmastlock !== 1'b1 || s_haddr !== 32'h0000_3000) begin errors++; $display("FAIL lock_fwd: got grant %0b lock %0b haddr %0h want 0 1 3000", grant, s_hmastlock, s_haddr); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b1);
    set_m1(2'b10, 32'h0000_6000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      @(negedge hclk);
      checks++; if (grant !== 1'b0 || m1_hready !== 1'b0) begin errors++; $display("FAIL lock_idle%0d: got grant %0b m1r %0b want 0 0", i, grant, m1_hready); end
    end
    step();
    set_m0(2'b10, 32'h0000_3004, 1'b0, 1'b1);
    @(negedge hclk);
    checks++; if (grant !== 1'b0 || s_haddr !== 32'h0000_3004) begin errors++; $display("FAIL lock_beat2: got grant %0b haddr %0h want 0 3004", grant, s_haddr); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge hclk);
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL lock_release: got grant %0b want 0", grant); end
    step();
    @(negedge hclk);
    checks++; if (grant !== 1'b1 || s_haddr !== 32'h0000_6000 || s_hmastlock !== 1'b0) begin errors++; $display("FAIL lock_switch: got grant %0b haddr %0h lock %0b want 1 6000 0", grant, s_haddr, s_hmastlock); end
    step();
    set_m1(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge hclk);
  endtask

  task automatic test_error;
    step();
    set_m1(2'b10, 32'hC000_0000, 1'b1, 1'b0);
    @(negedge hclk);
    checks++; if (s_haddr !== 32'hC000_0000 || s_hwrite !== 1'b1) begin errors++; $display("FAIL err_fwd: got haddr %0h hwrite %0b want c0000000 1", s_haddr, s_hwrite); end
    step();
    set_m1(2'b00, 32'h0, 1'b0, 1'b0);
    s_hresp = 1'b1; s_hready = 1'b0;
    @(negedge hclk);
    checks++; if (m1_hresp !== 1'b1 || m1_hready !== 1'b0 || m0_hresp !== 1'b0) begin errors++; $display("FAIL err_cycle1: got m1resp %0b m1r %0b m0resp %0b want 1 0 0", m1_hresp, m1_hready, m0_hresp); end
    step();
    s_hready = 1'b1;
    set_m0(2'b10, 32'h0000_0200, 1'b0, 1'b0);
    @(negedge hclk);
    checks++; if (m1_hresp !== 1'b1 || m1_hready !== 1'b1 || m0_hresp !== 1'b0 || m0_hready !== 1'b0) begin
      errors++; $display("FAIL err_cycle2: got m1resp %0b m1r %0b m0resp %0b m0r %0b want 1 1 0 0", m1_hresp, m1_hready, m0_hresp, m0_hready);
    end
    step();
    s_hresp = 1'b0;
    @(negedge hclk);
    checks++; if (grant !== 1'b0 || s_haddr !== 32'h0000_0200 || m1_hresp !== 1'b0) begin errors++; $display("FAIL err_handover: got grant %0b haddr %0h m1resp %0b want 0 200 0", grant, s_haddr, m1_hresp); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    set_m1(2'b10, 32'h0000_7000, 1'b0, 1'b0);
    m1_hburst = 3'b001;
    @(negedge hclk);
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL ar_pre: got grant %0b want 0", grant); end
    step();
    @(negedge hclk);
    checks++; if (grant !== 1'b1 || s_haddr !== 32'h0000_7000) begin errors++; $display("FAIL ar_own: got grant %0b haddr %0h want 1 7000", grant, s_haddr); end
    step();
    set_m1(2'b11, 32'h0000_7004, 1'b0, 1'b0);
    s_hrdata = 32'hBEEF_0000;
    @(negedge hclk);
    checks++; if (m1_hrdata !== 32'hBEEF_0000) begin errors++; $display("FAIL ar_rdata: got %0h want beef0000", m1_hrdata); end
    #1 hresetn = 1'b0;
    #1;
    checks++; if (grant !== 1'b0 || m1_hrdata !== 32'h0 || s_htrans !== 2'b00) begin errors++; $display("FAIL ar_async: got grant %0b m1_hrdata %0h htrans %0h want 0 0 0", grant, m1_hrdata, s_htrans); end
    step();
    hresetn = 1'b1;
    set_m1(2'b00, 32'h0, 1'b0, 1'b0);
    m1_hburst = 3'b000;
    s_hrdata = '0;
    set_m0(2'b10, 32'h0000_0100, 1'b0, 1'b0);
    @(negedge hclk);
    checks++; if (s_haddr !== 32'h0000_0100 || s_htrans !== 2'b10 || grant !== 1'b0) begin errors++; $display("FAIL ar_after: got haddr %0h htrans %0h grant %0b want 100 2 0", s_haddr, s_htrans, grant); end
    step();
    set_m0(2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  // Each master issues single transfers; every one must reach the slave once, in order,
  // and read data must come back to the issuer.
  task automatic test_random;
    logic        req_v[2], req_w[2], dp_v[2], dp_w[2], hr[2];
    logic [31:0] req_a[2], dp_a[2];
    logic        sdp_v, sdp_w, sr, st, sw, drained;
    logic [31:0] sdp_a, sa;
    logic [32:0] q0[$], q1[$], exp_t;
    hresetn = 1'b0;
    idle_all();
    step();
    hresetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; req_w[k] = 1'b0; req_a[k] = '0;
      dp_v[k] = 1'b0; dp_w[k] = 1'b0; dp_a[k] = '0;
    end
    sdp_v = 1'b0; sdp_w = 1'b0; sdp_a = '0;
    drained = 1'b1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      drained = !req_v[0] && !req_v[1] && !dp_v[0] && !dp_v[1] && !sdp_v;
      if (cyc >= 600 && drained) break;
      m0_htrans = req_v[0] ? 2'b10 : 2'b00; m0_haddr = req_a[0]; m0_hwrite = req_w[0];
      m0_hwdata = (dp_v[0] && dp_w[0]) ? ~dp_a[0] : 32'h0;
      m1_htrans = req_v[1] ? 2'b10 : 2'b00; m1_haddr = req_a[1]; m1_hwrite = req_w[1];
      m1_hwdata = (dp_v[1] && dp_w[1]) ? ~dp_a[1] : 32'h0;
      s_hrdata = sdp_v ? (sdp_a ^ RKEY) : $urandom;
      s_hready = ($urandom_range(0, 3) != 0);
      @(negedge hclk);
      if (s_hready && s_htrans[1]) begin
        checks++;
        if (s_haddr[31] ? (q1.size() == 0) : (q0.size() == 0)) begin
          errors++; $display("FAIL rnd_unexpected: got addr %0h want none pending", s_haddr);
        end else begin
          exp_t = s_haddr[31] ? q1.pop_front() : q0.pop_front();
          if ({s_hwrite, s_haddr} !== exp_t) begin errors++; $display("FAIL rnd_order: got %0h want %0h", {s_hwrite, s_haddr}, exp_t); end
        end
      end
      if (s_hready && sdp_v && sdp_w) begin
        checks++; if (s_hwdata !== ~sdp_a) begin errors++; $display("FAIL rnd_wdata: got %0h want %0h", s_hwdata, ~sdp_a); end
      end
      if (m0_hready && dp_v[0] && !dp_w[0]) begin
        checks++; if (m0_hrdata !== (dp_a[0] ^ RKEY)) begin errors++; $display("FAIL rnd_rdata0: got %0h want %0h", m0_hrdata, dp_a[0] ^ RKEY); end
      end
      if (m1_hready && dp_v[1] && !dp_w[1]) begin
        checks++; if (m1_hrdata !== (dp_a[1] ^ RKEY)) begin errors++; $display("FAIL rnd_rdata1: got %0h want %0h", m1_hrdata, dp_a[1] ^ RKEY); end
      end
      hr[0] = m0_hready; hr[1] = m1_hready;
      sr = s_hready; st = s_htrans[1]; sa = s_haddr; sw = s_hwrite;
      step();
      if (sr) begin sdp_v = st; sdp_a = sa; sdp_w = sw; end
      for (int k = 0; k < 2; k++) begin
        if (hr[k]) begin
          dp_v[k] = req_v[k]; dp_a[k] = req_a[k]; dp_w[k] = req_w[k];
          req_v[k] = (cyc < 600) && ($urandom_range(0, 2) == 0);
          if (req_v[k]) begin
            req_a[k] = {(k == 1), 29'($urandom), 2'b00};
            req_w[k] = 1'($urandom);
            if (k == 1) q1.push_back({req_w[k], req_a[k]});
            else        q0.push_back({req_w[k], req_a[k]});
          end
        end
      end
    end
    checks++; if (!drained) begin errors++; $display("FAIL rnd_drain: got pending transfers want none"); end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d/%0d unforwarded want 0/0", q0.size(), q1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_handover();
    test_wait_states();
    test_lock();
    test_error();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
